// File: rtl/freq_meter.sv
// Equal-precision frequency meter: the gate opens and closes on input rising edges.
// Define FREQ_METER_AVG4_EN to report the rounded mean of the last four results.
module freq_meter #(
   parameter int unsigned CLK_HZ         = 209715200,
   parameter int unsigned GATE_CYCLES    = 20971520,
   parameter int unsigned TIMEOUT_CYCLES = 41943040
) (
   input  logic        CLOCK,
   input  logic        rst,
   input  logic        en,
   input  logic        sig_in,
   output logic [31:0] freq_hz,
   output logic        freq_valid,
   output logic        busy,
   output logic        no_signal
);

   localparam int unsigned W         = 32;
   localparam int unsigned DW        = 64;
   localparam int unsigned CW        = 6;
   localparam int unsigned GATE_LAST = GATE_CYCLES - 1;
   localparam int unsigned TMO_LAST  = TIMEOUT_CYCLES - 1;

   typedef enum logic [2:0] {IDLE, WAIT_OPEN, GATE, MUL, DIV, DONE, TMO} state_t;

   state_t          state_q, state_d;
   logic [2:0]      sync_q, sync_d;
   logic [W-1:0]    timer_q, timer_d;
   logic [W-1:0]    nref_q, nref_d, nsig_q, nsig_d;
   logic [W-1:0]    nref_lat_q, nref_lat_d, nsig_lat_q, nsig_lat_d;
   logic [DW-1:0]   dvd_q, dvd_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    freq_hz_q, freq_hz_d;
   logic            freq_valid_q, freq_valid_d;
   logic            busy_q, busy_d;
   logic            no_signal_q, no_signal_d;
   logic            rise_c;
   logic [W:0]      rem_sh_c;
   logic [W-1:0]    quo_sat_c;
   logic [W-1:0]    result_c;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] x);
      return (x == '1) ? x : x + W'(1);
   endfunction

   // sync_q[0..1] is the two-flop synchroniser, sync_q[2] the edge-detect delay
   assign sync_d    = {sync_q[1:0], sig_in};
   assign rise_c    = sync_q[1] & ~sync_q[2];
   assign quo_sat_c = (dvd_q[DW-1:W] != '0) ? '1 : dvd_q[W-1:0];

`ifdef FREQ_METER_AVG4_EN
   logic [2:0][W-1:0] hist_q, hist_d;
   logic [1:0]        hcnt_q, hcnt_d;
   logic [W+1:0]      sum_c;

   // Running mean over the current result and up to three previous ones
   always_comb begin
      hist_d = hist_q;
      hcnt_d = hcnt_q;
      sum_c  = (W+2)'(quo_sat_c) + (W+2)'(hist_q[0]) + (W+2)'(hist_q[1]) + (W+2)'(hist_q[2]);
      unique case (hcnt_q)
         2'd1:    result_c = W'((sum_c + (W+2)'(1)) >> 1);
         2'd2:    result_c = W'((sum_c + (W+2)'(1)) / (W+2)'(3));
         2'd3:    result_c = W'((sum_c + (W+2)'(2)) >> 2);
         default: result_c = quo_sat_c;
      endcase
      if (state_q == IDLE || state_q == TMO) begin
         hist_d = '0;
         hcnt_d = '0;
      end else if (state_q == DONE) begin
         hist_d = {hist_q[1:0], quo_sat_c};
         hcnt_d = (hcnt_q == 2'd3) ? 2'd3 : hcnt_q + 2'd1;
      end
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         hcnt_q <= '0;
      end else begin
         hist_q <= hist_d;
         hcnt_q <= hcnt_d;
      end
   end
`else
   assign result_c = quo_sat_c;
`endif

   // Measurement sequencing, multiply and restoring divide
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      nref_d       = nref_q;
      nsig_d       = nsig_q;
      nref_lat_d   = nref_lat_q;
      nsig_lat_d   = nsig_lat_q;
      dvd_d        = dvd_q;
      rem_d        = rem_q;
      cnt_d        = cnt_q;
      freq_hz_d    = freq_hz_q;
      no_signal_d  = no_signal_q;
      freq_valid_d = 1'b0;
      rem_sh_c     = {rem_q, dvd_q[DW-1]};
      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = WAIT_OPEN;
               timer_d = '0;
            end
         end
         WAIT_OPEN: begin
            timer_d = sat_inc(timer_q);
            if (rise_c) begin
               nref_d  = '0;
               nsig_d  = '0;
               state_d = GATE;
            end else if (timer_q >= TMO_LAST) begin
               state_d = TMO;
            end
         end
         GATE: begin
            nref_d = sat_inc(nref_q);
            if (rise_c) nsig_d = sat_inc(nsig_q);
            if (rise_c && nref_q >= GATE_LAST) begin
               nref_lat_d = sat_inc(nref_q);
               nsig_lat_d = sat_inc(nsig_q);
               state_d    = MUL;
            end else if (nref_q >= TMO_LAST) begin
               state_d = TMO;
            end
         end
         MUL: begin
            dvd_d   = DW'(nsig_lat_q) * DW'(CLK_HZ) + DW'(nref_lat_q >> 1);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
         end
         DIV: begin
            if (rem_sh_c >= {1'b0, nref_lat_q}) begin
               rem_d = W'(rem_sh_c - {1'b0, nref_lat_q});
               dvd_d = {dvd_q[DW-2:0], 1'b1};
            end else begin
               rem_d = W'(rem_sh_c);
               dvd_d = {dvd_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '1) state_d = DONE;
         end
         DONE: begin
            freq_hz_d    = result_c;
            no_signal_d  = 1'b0;
            freq_valid_d = 1'b1;
            timer_d      = '0;
            state_d      = en ? WAIT_OPEN : IDLE;
         end
         TMO: begin
            freq_hz_d    = '0;
            no_signal_d  = 1'b1;
            freq_valid_d = 1'b1;
            timer_d      = '0;
            state_d      = en ? WAIT_OPEN : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!en && state_q != DONE && state_q != TMO) state_d = IDLE;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         timer_q      <= '0;
         nref_q       <= '0;
         nsig_q       <= '0;
         nref_lat_q   <= '0;
         nsig_lat_q   <= '0;
         dvd_q        <= '0;
         rem_q        <= '0;
         cnt_q        <= '0;
         freq_hz_q    <= '0;
         freq_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         no_signal_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         timer_q      <= timer_d;
         nref_q       <= nref_d;
         nsig_q       <= nsig_d;
         nref_lat_q   <= nref_lat_d;
         nsig_lat_q   <= nsig_lat_d;
         dvd_q        <= dvd_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         freq_hz_q    <= freq_hz_d;
         freq_valid_q <= freq_valid_d;
         busy_q       <= busy_d;
         no_signal_q  <= no_signal_d;
      end
   end

   assign freq_hz    = freq_hz_q;
   assign freq_valid = freq_valid_q;
   assign busy       = busy_q;
   assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: square waves on sig_in, results predicted from recorded rising edges.
module tb_freq_meter;

   localparam int unsigned CLK_HZ  = 1000000;
   localparam int unsigned GATE    = 1000;
   localparam int unsigned TIMEOUT = 2000;

   logic        CLOCK = 1'b0;
   logic        rst   = 1'b1;
   logic        en    = 1'b0;
   logic        sig_in = 1'b0;
   logic [31:0] freq_hz;
   logic        freq_valid;
   logic        busy;
   logic        no_signal;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Wave generator and model state
   bit     w_on = 0;
   int     w_period = 40, w_high = 20, w_cnt = 0;
   bit     prev_sig = 0;
   int     rises[$];
   longint hist[$];
   int     accept_from = 0;
   int     last_v = 0;
   logic [31:0] last_freq = '0;

   freq_meter #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .CLOCK(CLOCK), .rst(rst), .en(en), .sig_in(sig_in),
      .freq_hz(freq_hz), .freq_valid(freq_valid), .busy(busy), .no_signal(no_signal)
   );

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic tick();
      @(posedge CLOCK);
      #1;
      if (w_on) begin
         sig_in = (w_cnt < w_high);
         w_cnt  = (w_cnt + 1 == w_period) ? 0 : w_cnt + 1;
      end else begin
         sig_in = 1'b0;
      end
      if (sig_in && !prev_sig) rises.push_back(cyc);
      prev_sig = sig_in;
   endtask

   task automatic enable();
      en = 1'b1;
      accept_from = cyc - 1;
      hist.delete();
   endtask

   task automatic wait_valid(input int budget, output bit got);
      got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (freq_valid === 1'b1) got = 1;
      end
   endtask

   // Reference: gate spans the first accepted rise to the first rise >= GATE cycles later
   task automatic model_meas(output int exp_cyc, output longint exp_q, output bit found);
      int open_c, close_c;
      longint nsig, nref, sum;
      open_c = -1; close_c = -1; nsig = 0; found = 0; exp_cyc = -1; exp_q = 0;
      while (rises.size() > 0 && rises[0] < accept_from) void'(rises.pop_front());
      foreach (rises[i]) begin
         if (open_c < 0) open_c = rises[i];
         else if (close_c < 0) begin
            nsig++;
            if (rises[i] - open_c >= int'(GATE)) close_c = rises[i];
         end
      end
      if (close_c >= 0) begin
         found   = 1;
         nref    = longint'(close_c - open_c);
         exp_q   = (nsig * longint'(CLK_HZ) + nref / 2) / nref;
         if (exp_q > 64'hFFFFFFFF) exp_q = 64'hFFFFFFFF;
         exp_cyc = close_c + 3 + 66;
`ifdef FREQ_METER_AVG4_EN
         hist.push_back(exp_q);
         if (hist.size() > 4) void'(hist.pop_front());
         sum = 0;
         foreach (hist[i]) sum += hist[i];
         exp_q = (sum + longint'(hist.size() / 2)) / longint'(hist.size());
`else
         sum = 0;
`endif
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; w_on = 0;
      repeat (3) tick();
      checks++; if (freq_hz !== 32'd0) begin errors++; $display("FAIL reset_freq_hz: got %0d expected 0", freq_hz); end
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_freq_valid: got %b expected 0", freq_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL reset_no_signal: got %b expected 0", no_signal); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_stream(input string name, input int period, input int high, input int n);
      bit got, found;
      int ecyc;
      longint eq;
      w_period = period; w_high = high; w_cnt = high; w_on = 1;
      for (int k = 0; k < n; k++) begin
         wait_valid(5000, got);
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL %s_valid: freq_valid got 0 within 5000 cycles, expected 1", name);
            k = n;
         end else begin
            model_meas(ecyc, eq, found);
            checks++;
            if (!found || cyc !== ecyc) begin
               errors++; $display("FAIL %s_latency: freq_valid at cycle %0d expected %0d", name, cyc, ecyc);
            end
            checks++;
            if (freq_hz !== 32'(eq)) begin
               errors++; $display("FAIL %s_freq: got %0d expected %0d (period %0d)", name, freq_hz, eq, period);
            end
            checks++;
            if (no_signal !== 1'b0) begin
               errors++; $display("FAIL %s_no_signal: got %b expected 0", name, no_signal);
            end
            last_v = cyc; last_freq = 32'(eq);
            accept_from = cyc - 2;
            tick();
            checks++;
            if (freq_valid !== 1'b0) begin
               errors++; $display("FAIL %s_pulse_width: freq_valid got %b expected 0", name, freq_valid);
            end
         end
      end
   endtask

   task automatic test_random();
      int p, h;
      for (int i = 0; i < 4; i++) begin
         p = int'($urandom_range(150, 2));
         h = int'($urandom_range(p - 1, 1));
         test_stream("rand", p, h, 1);
      end
   endtask

   task automatic test_timeout();
      bit got;
      int a;
      en = 1'b0; w_on = 0;
      repeat (6) tick();
      enable();
      a = cyc;
      wait_valid(3000, got);
      checks++;
      if (!got) begin errors++; $display("FAIL tmo_valid: freq_valid got 0 within 3000 cycles, expected 1"); end
      checks++;
      if (cyc !== a + 2002) begin errors++; $display("FAIL tmo_latency: freq_valid at cycle %0d expected %0d", cyc, a + 2002); end
      checks++;
      if (freq_hz !== 32'd0) begin errors++; $display("FAIL tmo_freq: got %0d expected 0", freq_hz); end
      checks++;
      if (no_signal !== 1'b1) begin errors++; $display("FAIL tmo_no_signal: got %b expected 1", no_signal); end
      hist.delete();
      accept_from = cyc - 2;
      tick();
      test_stream("after_tmo", 40, 20, 1);
   endtask

   task automatic test_abort();
      bit seen;
      test_stream("abort_pre", 40, 20, 1);
      while (cyc < last_v + 200) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_gate: got %b expected 1", busy); end
      en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_fall: got %b expected 0", busy); end
      seen = 0;
      repeat (1500) begin
         tick();
         if (freq_valid === 1'b1) seen = 1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: freq_valid seen %b expected 0", seen); end
      checks++;
      if (freq_hz !== last_freq) begin errors++; $display("FAIL abort_hold: got %0d expected %0d", freq_hz, last_freq); end
      checks++;
      if (no_signal !== 1'b0) begin errors++; $display("FAIL abort_no_signal: got %b expected 0", no_signal); end
      enable();
   endtask

   task automatic test_reset_div();
      test_stream("rdiv_pre", 40, 20, 1);
      while (cyc < last_v + 1050) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rdiv_busy_pre: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      checks++;
      if (freq_hz !== 32'd0) begin errors++; $display("FAIL rdiv_freq_hz: got %0d expected 0", freq_hz); end
      checks++;
      if (freq_valid !== 1'b0) begin errors++; $display("FAIL rdiv_freq_valid: got %b expected 0", freq_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rdiv_busy: got %b expected 0", busy); end
      checks++;
      if (no_signal !== 1'b0) begin errors++; $display("FAIL rdiv_no_signal: got %b expected 0", no_signal); end
      w_on = 0;
      repeat (5) tick();
      rst = 1'b0;
      accept_from = cyc - 1;
      hist.delete();
      test_stream("rdiv_post", 40, 20, 2);
   endtask

   task automatic test_avg4();
      en = 1'b0;
      repeat (3) tick();
      enable();
      test_stream("avg_40a", 40, 20, 1);
      test_stream("avg_40b", 40, 20, 1);
      test_stream("avg_50a", 50, 25, 1);
      test_stream("avg_50b", 50, 25, 1);
   endtask

   initial begin
      test_reset();
      enable();
      test_stream("p40", 40, 20, 3);
      test_stream("p3", 3, 1, 2);
      test_random();
      test_timeout();
      test_abort();
      test_reset_div();
      test_avg4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Equal-precision (multi-period) frequency meter.
- Measures an external square wave, for example an NCO sign-bit output or a comparator-squared analog input.
- Reports frequency in 1 Hz units, the same scaling as the NCO 32-bit frequency control word, so meter and NCO can form a closed loop.
- Gate opens and closes on input rising edges, so quantisation error is ±1 reference cycle rather than ±1 signal cycle.

Parameters:
- CLK_HZ, 209715200: reference clock frequency in Hz; multiplier constant.
- GATE_CYCLES, 20971520: minimum gate length in CLOCK cycles (0.1 s at default).
- TIMEOUT_CYCLES, 41943040: cycles without a required edge before a no-signal result is declared.

Ports:
- CLOCK  input  1  reference clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  measurement enable; continuous back-to-back measurements while high.
- sig_in  input  1  asynchronous square-wave input.
- freq_hz  output  32  last result in Hz, rounded to nearest.
- freq_valid  output  1  one-cycle pulse when freq_hz/no_signal update.
- busy  output  1  high in any state except IDLE.
- no_signal  output  1  high when last result was a timeout.

Behaviour:
- Reset values: freq_hz=0, freq_valid=0, busy=0, no_signal=0, FSM=IDLE, all counters 0.
- Input conditioning:
  - sig_in passes a 2-FF synchroniser plus one delay FF.
  - rise = s1 & ~s2.
  - Max measurable frequency is CLK_HZ/2.
- IDLE: if en=1, go to WAIT_OPEN and clear the timer.
- WAIT_OPEN:
  - Timer increments each cycle.
  - On rise: nref<=0, nsig<=0, go to GATE.
  - If timer reaches TIMEOUT_CYCLES first, go to TMO.
- GATE:
  - nref increments every cycle.
  - nsig increments on every rise.
  - On a rise with nref>=GATE_CYCLES-1 (the closing edge): count that rise, latch Nref=nref+1 and Nsig, go to MUL.
  - If nref reaches TIMEOUT_CYCLES without a closing edge, go to TMO.
  - Nref therefore equals the exact cycle distance between the opening and closing edges.
- MUL (1 cycle): dividend = Nsig*CLK_HZ + (Nref>>1), 64-bit unsigned.
- DIV (64 cycles): restoring divider, one quotient bit per cycle, 64-bit dividend, 32-bit divisor Nref.
- DONE (1 cycle):
  - freq_hz <= quotient, saturated to 32'hFFFFFFFF if quotient[63:32]!=0.
  - no_signal<=0, freq_valid=1.
  - Then go to WAIT_OPEN if en=1, else IDLE.
- TMO (1 cycle): freq_hz<=0, no_signal<=1, freq_valid=1, then go to WAIT_OPEN if en=1, else IDLE.
- Latency: closing edge detected -> freq_valid = 66 cycles (MUL 1 + DIV 64 + DONE 1).
- en deasserted in any state other than DONE/TMO: abort to IDLE next cycle, no freq_valid pulse, freq_hz/no_signal hold.
- nsig and nref saturate at all-ones and never wrap.
- Rise in the same cycle as the timeout threshold: the rise wins.
- A rise arriving during MUL/DIV is ignored; the next measurement opens on the first rise seen in WAIT_OPEN.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro FREQ_METER_AVG4_EN.
- Defined: freq_hz reports the mean of the last 4 valid quotients, as (sum+2)>>2 with a 34-bit sum, updated at each DONE.
  - Until 4 results exist, the mean is over those available (1, 2 or 3, rounded).
  - TMO or en low clears the history.
  - freq_valid timing is unchanged.
- Undefined: freq_hz is the single-measurement quotient.

Test Plan:
- CLK_HZ=1000000, GATE_CYCLES=1000, TIMEOUT_CYCLES=2000, sig_in period 40 cycles, en=1 -> Nref=1000, Nsig=25, freq_hz=25000, no_signal=0, freq_valid 66 cycles after closing edge, repeating.
- Same params, period 3 (1 high/2 low) -> Nref=1002, Nsig=334, freq_hz=333333.
- Same params, sig_in held 0 -> freq_valid pulse after 2000 cycles in WAIT_OPEN, freq_hz=0, no_signal=1; then period 40 applied -> next result 25000, no_signal=0.
- Period 40, en dropped mid-GATE -> busy falls next cycle, no freq_valid, freq_hz holds previous 25000.
- rst pulsed during DIV -> all outputs 0 immediately, FSM IDLE; after release with en=1, a correct measurement follows.
- FREQ_METER_AVG4_EN defined, periods 40,40,50,50 on successive measurements -> freq_hz = 25000, 25000, 23333, 22500.
